// File: rtl/mc_cu_pkg.sv
// mc_cu_pkg: shared definitions for the multicycle control unit.
// Holds the FSM state codes, the instruction classes that the decoder
// reports, the ALU operation codes, the opcode/function constants and the
// ALU operand and PC source select encodings.
package mc_cu_pkg;

  // FSM state codes; the 3-bit values appear directly on the state port
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [3:0] {
    C_ILLEGAL, C_ALU_R, C_ALU_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR
  } iclass_e;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_HAMM = 4'b1011;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_HAMM = 6'b110010;

  // ALU operand B select
  localparam logic [1:0] BSRC_REG     = 2'b00;
  localparam logic [1:0] BSRC_FOUR    = 2'b01;
  localparam logic [1:0] BSRC_IMM     = 2'b10;
  localparam logic [1:0] BSRC_IMM_SL2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_REGA   = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

endpackage

// File: rtl/mc_cu_dec.sv
// mc_cu_dec: purely combinational instruction decoder.
// Ports:
//   op, func  - opcode and function fields of the instruction register
//   iclass    - instruction class (C_ILLEGAL for anything unsupported)
//   aluc      - ALU operation for the execute step
//   shift     - shift instruction (ALU operand A comes from the shamt field)
//   sext      - sign-extend the immediate
//   regrt     - destination register is rt (I-type)
//   legal     - instruction is supported
// HAMM_EN selects whether the hamm R-type function is accepted.
module mc_cu_dec
  import mc_cu_pkg::*;
#(
  parameter bit HAMM_EN = 1'b1
) (
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_e    iclass,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       sext,
  output logic       regrt,
  output logic       legal
);

  // Table lookup from opcode/function to class and ALU controls
  always_comb begin
    iclass = C_ILLEGAL;
    aluc   = ALU_ADD;
    shift  = 1'b0;
    sext   = 1'b0;
    regrt  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: iclass = C_ALU_R;
          FN_SUB: begin iclass = C_ALU_R; aluc = ALU_SUB; end
          FN_AND: begin iclass = C_ALU_R; aluc = ALU_AND; end
          FN_OR:  begin iclass = C_ALU_R; aluc = ALU_OR;  end
          FN_XOR: begin iclass = C_ALU_R; aluc = ALU_XOR; end
          FN_SLL: begin iclass = C_ALU_R; aluc = ALU_SLL; shift = 1'b1; end
          FN_SRL: begin iclass = C_ALU_R; aluc = ALU_SRL; shift = 1'b1; end
          FN_SRA: begin iclass = C_ALU_R; aluc = ALU_SRA; shift = 1'b1; end
          FN_JR:  iclass = C_JR;
          FN_HAMM: begin
            if (HAMM_EN) begin
              iclass = C_ALU_R;
              aluc   = ALU_HAMM;
            end
          end
          default: ;
        endcase
      end
      OP_ADDI: begin iclass = C_ALU_I; sext = 1'b1; regrt = 1'b1; end
      OP_ANDI: begin iclass = C_ALU_I; aluc = ALU_AND; regrt = 1'b1; end
      OP_ORI:  begin iclass = C_ALU_I; aluc = ALU_OR;  regrt = 1'b1; end
      OP_XORI: begin iclass = C_ALU_I; aluc = ALU_XOR; regrt = 1'b1; end
      OP_LUI:  begin iclass = C_ALU_I; aluc = ALU_LUI; regrt = 1'b1; end
      OP_LW:   begin iclass = C_LW; sext = 1'b1; regrt = 1'b1; end
      OP_SW:   begin iclass = C_SW; sext = 1'b1; regrt = 1'b1; end
      OP_BEQ:  begin iclass = C_BEQ; aluc = ALU_SUB; sext = 1'b1; end
      OP_BNE:  begin iclass = C_BNE; aluc = ALU_SUB; sext = 1'b1; end
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      default: ;
    endcase
    legal = (iclass != C_ILLEGAL);
  end

endmodule

// File: rtl/mc_cu.sv
// mc_cu: multicycle control unit (FSM, memory wait counter, output muxing).
// Ports:
//   clock, resetn       - clock and synchronous active-low reset
//   op, func            - instruction fields from the external IR
//   z                   - ALU zero flag (same cycle)
//   mem_ready           - memory completion strobe
//   mem_req .. sext     - 1-bit datapath controls
//   aluc, alusrcb       - ALU operation and operand B select
//   pcsource            - next-PC select
//   state               - current FSM state code
//   illegal, bus_err    - halt cause, visible while halted
// Controls are Mealy outputs: fetch/branch/memory writes depend on
// mem_ready and z in the same cycle, and every output is forced low
// whenever resetn is low.
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter bit          HAMM_EN     = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       shift,
  output logic       alusrca,
  output logic       jal,
  output logic       sext,
  output logic [3:0] aluc,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err
);

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      cur, nxt;
  logic [15:0] wait_cnt;
  logic        illegal_q, bus_err_q;
  iclass_e     iclass;
  logic [3:0]  d_aluc;
  logic        d_shift, d_sext, d_regrt, d_legal;
  logic        timed_out;

  mc_cu_dec #(.HAMM_EN(HAMM_EN)) u_dec (
    .op     (op),
    .func   (func),
    .iclass (iclass),
    .aluc   (d_aluc),
    .shift  (d_shift),
    .sext   (d_sext),
    .regrt  (d_regrt),
    .legal  (d_legal)
  );

  // This cycle would be wait number MEM_TIMEOUT; a same-cycle mem_ready
  // is checked first in the next-state logic so it still wins.
  assign timed_out = (wait_cnt == WAIT_LAST);

  // Next-state selection
  always_comb begin
    nxt = cur;
    case (cur)
      S_IF: begin
        if (mem_ready)      nxt = S_ID;
        else if (timed_out) nxt = S_HALT;
      end
      S_ID: begin
        if (!d_legal)                                          nxt = S_HALT;
        else if (iclass == C_J || iclass == C_JAL || iclass == C_JR) nxt = S_IF;
        else                                                   nxt = S_EXE;
      end
      S_EXE: begin
        case (iclass)
          C_BEQ, C_BNE: nxt = S_IF;
          C_LW, C_SW:   nxt = S_MEM;
          default:      nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready)      nxt = (iclass == C_LW) ? S_WB : S_IF;
        else if (timed_out) nxt = S_HALT;
      end
      S_WB:    nxt = S_IF;
      default: nxt = S_HALT;
    endcase
  end

  // State register, wait counter and sticky halt causes. Any state change
  // clears the counter, which covers every entry into IF and MEM.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cur       <= S_IF;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + 16'd1;
      if (cur == S_ID && nxt == S_HALT)
        illegal_q <= 1'b1;
      if ((cur == S_IF || cur == S_MEM) && nxt == S_HALT)
        bus_err_q <= 1'b1;
    end
  end

  // Output muxing per state; everything stays at zero while in reset
  always_comb begin
    mem_req  = 1'b0;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    jal      = 1'b0;
    sext     = 1'b0;
    aluc     = ALU_ADD;
    alusrcb  = BSRC_REG;
    pcsource = PCSRC_ALU;
    state    = 3'd0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    if (resetn) begin
      state = cur;
      case (cur)
        S_IF: begin
          mem_req = 1'b1;
          alusrcb = BSRC_FOUR;
          wpc     = mem_ready;
          wir     = mem_ready;
        end
        S_ID: begin
          // branch target precompute; the offset is sign-extended
          alusrcb = BSRC_IMM_SL2;
          sext    = 1'b1;
          case (iclass)
            C_J:  begin wpc = 1'b1; pcsource = PCSRC_JUMP; end
            C_JAL: begin
              wpc      = 1'b1;
              wreg     = 1'b1;
              jal      = 1'b1;
              pcsource = PCSRC_JUMP;
            end
            C_JR: begin wpc = 1'b1; pcsource = PCSRC_REGA; end
            default: ;
          endcase
        end
        S_EXE: begin
          case (iclass)
            C_BEQ, C_BNE: begin
              alusrca  = 1'b1;
              aluc     = ALU_SUB;
              pcsource = PCSRC_BRANCH;
              wpc      = (iclass == C_BEQ) ? z : !z;
            end
            C_LW, C_SW: begin
              alusrca = 1'b1;
              alusrcb = BSRC_IMM;
              sext    = 1'b1;
            end
            C_ALU_R: begin
              alusrca = !d_shift;
              aluc    = d_aluc;
              shift   = d_shift;
              sext    = d_sext;
            end
            C_ALU_I: begin
              alusrca = 1'b1;
              alusrcb = BSRC_IMM;
              aluc    = d_aluc;
              sext    = d_sext;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          wmem    = (iclass == C_SW);
        end
        S_WB: begin
          wreg  = 1'b1;
          m2reg = (iclass == C_LW);
          regrt = d_regrt;
        end
        default: begin
          state   = S_HALT;
          illegal = illegal_q;
          bus_err = bus_err_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: self-checking bench for mc_cu.
// Each instruction is expanded into its expected sequence of steps
// (fetch with memory waits, decode, execute, memory, write-back) and every
// cycle's full output vector is compared against the expected controls.
// A second instance with hamm disabled checks the illegal-instruction halt.
module tb_mc_cu;

  localparam int T = 4;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9;
  localparam int PH_IF = 0, PH_ID = 1, PH_EXE = 2, PH_MEM = 3, PH_WB = 4, PH_HALT = 5;

  typedef struct packed {
    logic [2:0] st;
    logic ill, berr, mreq, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, asrca, jal, sext;
    logic [3:0] aluc;
    logic [1:0] bsrc, pcs;
  } ov_t;

  typedef struct {
    int         kind;
    logic [3:0] aluc;
    logic       shift, sext, itype;
  } info_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] op = 6'd0, func = 6'd0;
  logic       z = 1'b0, mem_ready = 1'b0;

  logic mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext;
  logic [3:0] aluc;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] state;
  logic illegal, bus_err;

  logic h_mem_req, h_wpc, h_wir, h_wmem, h_wreg, h_iord, h_regrt, h_m2reg, h_shift;
  logic h_alusrca, h_jal, h_sext;
  logic [3:0] h_aluc;
  logic [1:0] h_alusrcb, h_pcsource;
  logic [2:0] h_state;
  logic h_illegal, h_bus_err;

  logic [24:0] act, act2;
  assign act  = {state, illegal, bus_err, mem_req, wpc, wir, wmem, wreg, iord, regrt,
                 m2reg, shift, alusrca, jal, sext, aluc, alusrcb, pcsource};
  assign act2 = {h_state, h_illegal, h_bus_err, h_mem_req, h_wpc, h_wir, h_wmem, h_wreg,
                 h_iord, h_regrt, h_m2reg, h_shift, h_alusrca, h_jal, h_sext, h_aluc,
                 h_alusrcb, h_pcsource};

  int errors = 0;
  int checks = 0;
  bit halted = 1'b0;
  bit m_ill = 1'b0, m_berr = 1'b0;

  localparam int N = 24;
  logic [5:0] prog_op [N] = '{6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00,
                              6'o00, 6'o00, 6'o10, 6'o14, 6'o15, 6'o16, 6'o17, 6'o43,
                              6'o53, 6'o04, 6'o05, 6'o02, 6'o03, 6'o00, 6'o77, 6'o20};
  logic [5:0] prog_fn [N] = '{6'o40, 6'o42, 6'o44, 6'o45, 6'o46, 6'o00, 6'o02, 6'o03,
                              6'o62, 6'o10, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00,
                              6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o77, 6'o00, 6'o00};
  localparam int I_ADD = 0, I_HAMM = 8, I_LW = 15, I_SW = 16, I_BEQ = 17, I_BNE = 18;

  mc_cu #(.HAMM_EN(1'b1), .MEM_TIMEOUT(T)) dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req), .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
    .regrt(regrt), .m2reg(m2reg), .shift(shift), .alusrca(alusrca), .jal(jal),
    .sext(sext), .aluc(aluc), .alusrcb(alusrcb), .pcsource(pcsource), .state(state),
    .illegal(illegal), .bus_err(bus_err)
  );

  mc_cu #(.HAMM_EN(1'b0)) dut_nohamm (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .mem_req(h_mem_req), .wpc(h_wpc), .wir(h_wir), .wmem(h_wmem), .wreg(h_wreg),
    .iord(h_iord), .regrt(h_regrt), .m2reg(h_m2reg), .shift(h_shift),
    .alusrca(h_alusrca), .jal(h_jal), .sext(h_sext), .aluc(h_aluc),
    .alusrcb(h_alusrcb), .pcsource(h_pcsource), .state(h_state),
    .illegal(h_illegal), .bus_err(h_bus_err)
  );

  always #5 clock = ~clock;

  // Instruction meaning straight from the instruction-set table
  function automatic info_t classify(input logic [5:0] o, input logic [5:0] f, input bit hamm_en);
    info_t r;
    r.kind = K_ILL; r.aluc = 4'b0000; r.shift = 1'b0; r.sext = 1'b0; r.itype = 1'b0;
    case (o)
      6'o00: case (f)
        6'o40: r.kind = K_R;
        6'o42: begin r.kind = K_R; r.aluc = 4'b0100; end
        6'o44: begin r.kind = K_R; r.aluc = 4'b0001; end
        6'o45: begin r.kind = K_R; r.aluc = 4'b0101; end
        6'o46: begin r.kind = K_R; r.aluc = 4'b0010; end
        6'o00: begin r.kind = K_R; r.aluc = 4'b0011; r.shift = 1'b1; end
        6'o02: begin r.kind = K_R; r.aluc = 4'b0111; r.shift = 1'b1; end
        6'o03: begin r.kind = K_R; r.aluc = 4'b1111; r.shift = 1'b1; end
        6'o10: r.kind = K_JR;
        6'o62: if (hamm_en) begin r.kind = K_R; r.aluc = 4'b1011; end
        default: ;
      endcase
      6'o10: begin r.kind = K_I; r.sext = 1'b1; r.itype = 1'b1; end
      6'o14: begin r.kind = K_I; r.aluc = 4'b0001; r.itype = 1'b1; end
      6'o15: begin r.kind = K_I; r.aluc = 4'b0101; r.itype = 1'b1; end
      6'o16: begin r.kind = K_I; r.aluc = 4'b0010; r.itype = 1'b1; end
      6'o17: begin r.kind = K_I; r.aluc = 4'b0110; r.itype = 1'b1; end
      6'o43: begin r.kind = K_LW; r.sext = 1'b1; r.itype = 1'b1; end
      6'o53: begin r.kind = K_SW; r.sext = 1'b1; r.itype = 1'b1; end
      6'o04: r.kind = K_BEQ;
      6'o05: r.kind = K_BNE;
      6'o02: r.kind = K_J;
      6'o03: r.kind = K_JAL;
      default: ;
    endcase
    return r;
  endfunction

  // Controls expected in one step of an instruction
  function automatic ov_t expOut(input int ph, input info_t inf, input logic mr,
                                 input logic zv, input logic ill, input logic berr);
    ov_t e = '0;
    case (ph)
      PH_IF: begin
        e.st = 3'd0; e.mreq = 1'b1; e.bsrc = 2'b01; e.wpc = mr; e.wir = mr;
      end
      PH_ID: begin
        e.st = 3'd1; e.bsrc = 2'b11; e.sext = 1'b1;
        if (inf.kind == K_J)   begin e.wpc = 1'b1; e.pcs = 2'b11; end
        if (inf.kind == K_JAL) begin e.wpc = 1'b1; e.wreg = 1'b1; e.jal = 1'b1; e.pcs = 2'b11; end
        if (inf.kind == K_JR)  begin e.wpc = 1'b1; e.pcs = 2'b10; end
      end
      PH_EXE: begin
        e.st = 3'd2;
        if (inf.kind == K_BEQ || inf.kind == K_BNE) begin
          e.asrca = 1'b1; e.aluc = 4'b0100; e.pcs = 2'b01;
          e.wpc = (inf.kind == K_BEQ) ? zv : !zv;
        end else if (inf.kind == K_LW || inf.kind == K_SW) begin
          e.asrca = 1'b1; e.bsrc = 2'b10; e.sext = 1'b1;
        end else begin
          e.asrca = !inf.shift; e.shift = inf.shift; e.aluc = inf.aluc; e.sext = inf.sext;
          e.bsrc = (inf.kind == K_I) ? 2'b10 : 2'b00;
        end
      end
      PH_MEM: begin
        e.st = 3'd3; e.mreq = 1'b1; e.iord = 1'b1; e.wmem = (inf.kind == K_SW);
      end
      PH_WB: begin
        e.st = 3'd4; e.wreg = 1'b1; e.m2reg = (inf.kind == K_LW); e.regrt = inf.itype;
      end
      default: begin
        e.st = 3'd5; e.ill = ill; e.berr = berr;
      end
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic mr, input logic zv);
    mem_ready = mr;
    z = zv;
  endtask

  // Check the main instance mid-cycle, then advance just past the next edge
  task automatic runCycle(input string tag, input ov_t e);
    @(negedge clock);
    checkOutput(tag, act, e);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    op = 6'($urandom);
    applyStimulus(1'($urandom), 1'($urandom));
    runCycle("reset", '0);
    resetn = 1'b1;
    halted = 1'b0; m_ill = 1'b0; m_berr = 1'b0;
  endtask

  // One instruction: wif/wmem are memory wait cycles (>= T means timeout),
  // rst_at > 0 pulls reset on that memory wait cycle of MEM
  task automatic runInstr(input int idx, input int wif, input int wmem_n,
                          input logic zv, input int rst_at);
    info_t inf;
    inf = classify(prog_op[idx], prog_fn[idx], 1'b1);
    op = prog_op[idx];
    func = prog_fn[idx];
    for (int k = 0; k < wif && k < T; k++) begin
      applyStimulus(1'b0, 1'($urandom));
      runCycle("if_wait", expOut(PH_IF, inf, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    if (wif >= T) begin halted = 1'b1; m_berr = 1'b1; return; end
    applyStimulus(1'b1, 1'($urandom));
    runCycle("if_fetch", expOut(PH_IF, inf, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'($urandom), zv);
    runCycle("id", expOut(PH_ID, inf, 1'b0, zv, 1'b0, 1'b0));
    if (inf.kind == K_ILL) begin halted = 1'b1; m_ill = 1'b1; return; end
    if (inf.kind == K_J || inf.kind == K_JAL || inf.kind == K_JR) return;
    applyStimulus(1'($urandom), zv);
    runCycle("exe", expOut(PH_EXE, inf, 1'b0, zv, 1'b0, 1'b0));
    if (inf.kind == K_BEQ || inf.kind == K_BNE) return;
    if (inf.kind == K_LW || inf.kind == K_SW) begin
      for (int k = 0; k < wmem_n && k < T; k++) begin
        applyStimulus(1'b0, 1'($urandom));
        if (rst_at == k + 1) begin
          resetn = 1'b0;
          runCycle("mem_rst", '0);
          resetn = 1'b1;
          m_ill = 1'b0; m_berr = 1'b0;
          return;
        end
        runCycle("mem_wait", expOut(PH_MEM, inf, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      if (wmem_n >= T) begin halted = 1'b1; m_berr = 1'b1; return; end
      applyStimulus(1'b1, 1'($urandom));
      runCycle("mem_done", expOut(PH_MEM, inf, 1'b1, 1'b0, 1'b0, 1'b0));
      if (inf.kind == K_SW) return;
    end
    applyStimulus(1'($urandom), 1'($urandom));
    runCycle("wb", expOut(PH_WB, inf, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Observe the halt for a few cycles, then recover through reset
  task automatic settle();
    info_t none;
    none = classify(6'o77, 6'o00, 1'b1);
    if (halted) begin
      for (int k = 0; k < 2; k++) begin
        applyStimulus(1'($urandom), 1'($urandom));
        runCycle("halt", expOut(PH_HALT, none, 1'b0, 1'b0, m_ill, m_berr));
      end
      doReset();
    end
  endtask

  initial begin
    info_t h0, h1;
    int idx, wif, wmm, rst_at;

    doReset();

    // directed cases
    runInstr(I_ADD, 0, 0, 1'b0, 0);  settle();
    runInstr(I_LW, 0, 3, 1'b0, 0);   settle();
    runInstr(I_BEQ, 0, 0, 1'b1, 0);  settle();
    runInstr(I_BNE, 0, 0, 1'b1, 0);  settle();
    for (int i = 9; i < 21; i++) begin runInstr(i, 0, 1, 1'b0, 0); settle(); end
    runInstr(21, 0, 0, 1'b0, 0);     settle();
    runInstr(22, 1, 0, 1'b0, 0);     settle();
    runInstr(I_ADD, T, 0, 1'b0, 0);  settle();
    runInstr(I_LW, T - 1, T - 1, 1'b0, 0); settle();
    runInstr(I_SW, 0, 3, 1'b0, 2);   settle();
    runInstr(I_SW, 0, T, 1'b0, 0);   settle();

    // hamm on both instances: legal on one, illegal halt on the other
    h0 = classify(6'o00, 6'o62, 1'b0);
    h1 = classify(6'o00, 6'o62, 1'b1);
    op = 6'o00; func = 6'o62;
    applyStimulus(1'b1, 1'b0);
    @(negedge clock);
    checkOutput("h0_if", act2, expOut(PH_IF, h0, 1'b1, 1'b0, 1'b0, 1'b0));
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0);
    @(negedge clock);
    checkOutput("h0_id", act2, expOut(PH_ID, h0, 1'b0, 1'b0, 1'b0, 1'b0));
    checkOutput("h1_id", act, expOut(PH_ID, h1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("h0_halt", act2, expOut(PH_HALT, h0, 1'b0, 1'b0, 1'b1, 1'b0));
    checkOutput("h1_exe", act, expOut(PH_EXE, h1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("h0_hold", act2, expOut(PH_HALT, h0, 1'b0, 1'b0, 1'b1, 1'b0));
    @(posedge clock); #1;
    doReset();

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      idx = $urandom_range(0, N - 1);
      wif = ($urandom_range(0, 24) == 0) ? T : $urandom_range(0, T - 1);
      wmm = ($urandom_range(0, 24) == 0) ? T : $urandom_range(0, T - 1);
      rst_at = (wmm > 0 && wmm < T && $urandom_range(0, 19) == 0) ? $urandom_range(1, wmm) : 0;
      runInstr(idx, wif, wmm, 1'($urandom), rst_at);
      settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_cu.md
MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 SHALL have parameter HAMM_EN, default 1; when 1, R-type func 110010 (hamm) is legal, otherwise it is an illegal instruction.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255; this is the maximum wait cycles for mem_ready, range 1..65535.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset that is synchronous and active-low.
REQ-005 SHALL have ports op and func, inputs, 6 bits each: opcode and function fields taken from the external IR.
REQ-006 SHALL have port z, input, 1 bit: ALU zero flag, combinational in the current cycle.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory completion strobe.
REQ-008 SHALL have ports mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal and sext, outputs, 1 bit each: datapath controls.
REQ-009 SHALL have port aluc, output, 4 bits, using the existing ALU encoding: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111, hamm 1011.
REQ-010 SHALL have port alusrcb, output, 2 bits: 00 reg B, 01 constant 4, 10 extended immediate, 11 extended immediate shifted left 2.
REQ-011 SHALL have port pcsource, output, 2 bits: 00 ALU result, 01 branch target, 10 reg A (jr), 11 jump address.
REQ-012 SHALL have port state, output, 3 bits, and ports illegal and bus_err, outputs, 1 bit each: status.

Function
REQ-013 SHALL use states IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6 and 7 are unreachable and SHALL map to HALT.
REQ-014 IF SHALL assert mem_req with iord=0 and hold it until mem_ready; on mem_ready it SHALL assert wpc, wir, alusrca=0, alusrcb=01, aluc=add, pcsource=00, then go to ID.
REQ-015 ID SHALL drive alusrca=0, alusrcb=11, aluc=add (branch target precompute).
REQ-016 ID with j SHALL assert wpc and pcsource=11, then go to IF.
REQ-017 ID with jal SHALL additionally assert wreg and jal, then go to IF.
REQ-018 ID with jr SHALL assert wpc and pcsource=10, then go to IF.
REQ-019 ID with an illegal op/func SHALL go to HALT; all other instructions go to EXE.
REQ-020 EXE beq/bne SHALL drive alusrca=1, alusrcb=00, aluc=sub; wpc=(beq&z)|(bne&~z), pcsource=01; then go to IF.
REQ-021 EXE for R-type and immediate ALU instructions SHALL drive alusrca=~shift, alusrcb (00 R-type, 10 immediate), aluc, shift and sext per instruction, then go to WB.
REQ-022 EXE for lw/sw SHALL drive alusrca=1, alusrcb=10, sext=1, aluc=add, then go to MEM.
REQ-023 MEM SHALL assert mem_req and iord=1; for sw, wmem SHALL be asserted concurrently with mem_req.
REQ-024 MEM on mem_ready SHALL go to WB for lw and to IF for sw.
REQ-025 WB SHALL assert wreg, with m2reg=lw and regrt=I-type, then go to IF.
REQ-026 Latency with zero wait states SHALL be: j/jal/jr 2 cycles, beq/bne 3, ALU/sw 4, lw 5; each memory wait cycle adds 1.
REQ-027 A wait counter SHALL clear on entry to IF/MEM and increment each cycle mem_req is high without mem_ready.
REQ-028 When the wait counter reaches MEM_TIMEOUT, the block SHALL go to HALT with bus_err=1; mem_ready on the same cycle wins over the timeout.
REQ-029 HALT SHALL force all write enables and mem_req to 0, hold illegal or bus_err (whichever caused entry), and remain there until reset.
REQ-030 Write enables (wpc, wir, wmem, wreg) SHALL be asserted only in the states listed above and never for more than one cycle, except wmem, which is held through memory waits.
REQ-031 A mem_ready arriving while mem_req is 0 SHALL be ignored.

Reset
REQ-032 While resetn=0 at a clock edge: state:=IF, wait counter:=0, illegal:=0, bus_err:=0.
REQ-033 All outputs SHALL be 0 while resetn is low.
REQ-034 Reset mid-operation (including during MEM of sw) SHALL deassert wmem and mem_req in the same cycle; no partial write is retried.
REQ-035 The first mem_req SHALL be issued in the cycle after resetn rises.

Structure
REQ-036 The package mc_cu_pkg SHALL hold the state codes, aluc codes, op/func constants, and alusrcb/pcsource encodings.
REQ-037 The combinational decoder SHALL be sub-module mc_cu_dec (op, func -> instruction class, aluc, shift, sext, regrt, legal, HAMM_EN).
REQ-038 mc_cu SHALL contain only the FSM, the wait counter and output muxing.

Verification
REQ-039 add with mem_ready tied 1 -> state sequence 0,1,2,4,0; wreg high exactly in cycle 4; aluc=0000.
REQ-040 lw with mem_ready delayed 3 cycles in MEM -> 8 cycles total; m2reg=1, regrt=1 in WB.
REQ-041 beq with z=1, then bne with z=1 -> wpc=1, pcsource=01 for beq; wpc=0 for bne; both return to IF after 3 cycles.
REQ-042 HAMM_EN=0 with func 110010 -> HALT, illegal=1, no wreg; HAMM_EN=1 -> aluc=1011 in EXE.
REQ-043 MEM_TIMEOUT=4 with mem_ready held 0 in IF -> HALT after 4 wait cycles with bus_err=1; resetn=0 for one cycle -> state=0, bus_err=0.
REQ-044 sw with resetn pulled low during its second MEM wait cycle -> wmem=0 from that cycle; IF restarts.
